async_fifo_block: RTL and testbench



---
 rtl/async_fifo_block_if.sv | 22 ++
 rtl/async_fifo_block.sv | 49 ++++
 tb/tb_async_fifo_block.sv | 127 ++++++++++++
 3 files changed

// File: rtl/async_fifo_block_if.sv
// Producer/consumer handshake bundle for async_fifo_block.
// The FIFO takes the slave side. The producer/consumer logic takes the master side.
interface async_fifo_block_if #(
  parameter int d_width = 8
);
  logic               w_en;
  logic               r_en;
  logic [d_width-1:0] wr_data;
  logic [d_width-1:0] rd_data;
  logic               full;
  logic               empty;

  modport master (
    output w_en, r_en, wr_data,
    input  rd_data, full, empty
  );

  modport slave (
    input  w_en, r_en, wr_data,
    output rd_data, full, empty
  );
endinterface

// File: rtl/async_fifo_block.sv
// Single-clock FIFO with wrap-bit pointers and a registered read port.
// Flags are decoded from the pre-edge pointers, so a full FIFO refuses writes and an empty FIFO refuses reads.
module async_fifo_block #(
  parameter int depth   = 8,
  parameter int d_width = 8
) (
  input logic               wclk,
  input logic               reset,
  async_fifo_block_if.slave bus
);
  localparam int aw = $clog2(depth);

  logic [d_width-1:0] mem [depth];
  logic [aw:0]        wptr;
  logic [aw:0]        rptr;
  logic [d_width-1:0] rd_q;
  logic               full_c;
  logic               empty_c;
  logic               w_acc;
  logic               r_acc;

  assign empty_c = (wptr == rptr);
  assign full_c  = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);
  assign w_acc   = bus.w_en && !full_c;
  assign r_acc   = bus.r_en && !empty_c;

  assign bus.full    = full_c;
  assign bus.empty   = empty_c;
  assign bus.rd_data = rd_q;

  always_ff @(posedge wclk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      rd_q <= '0;
    end else begin
      if (w_acc) wptr <= wptr + 1'b1;
      if (r_acc) begin
        rd_q <= mem[rptr[aw-1:0]];
        rptr <= rptr + 1'b1;
      end
    end
  end

  // The storage array has no reset. Writes are gated by reset so that a reset cycle leaves the array unchanged.
  always_ff @(posedge wclk) begin
    if (!reset && w_acc) mem[wptr[aw-1:0]] <= bus.wr_data;
  end
endmodule

// File: tb/tb_async_fifo_block.sv
// Directed test of async_fifo_block, checked against a queue-based reference model.
module tb_async_fifo_block;
  localparam int depth   = 8;
  localparam int d_width = 8;

  logic wclk = 1'b0;
  logic reset;

  async_fifo_block_if #(.d_width(d_width)) bus ();

  async_fifo_block #(.depth(depth), .d_width(d_width)) dut (
    .wclk  (wclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 wclk = ~wclk;

  int n_vec = 0;
  int n_err = 0;
  logic [d_width-1:0] sb[$];
  logic [d_width-1:0] exp_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_rd"},    32'(bus.rd_data), 32'(exp_rd));
    chk({tag, "_empty"}, 32'(bus.empty),   32'(sb.size() == 0));
    chk({tag, "_full"},  32'(bus.full),    32'(sb.size() == depth));
  endtask

  // One clock: drive the inputs, update the model from the state before the edge, then sample after the edge.
  task automatic cycle(input logic w, input logic r, input logic [d_width-1:0] d, input string tag);
    logic was_full, was_empty;
    bus.w_en    = w;
    bus.r_en    = r;
    bus.wr_data = d;
    was_full  = (sb.size() == depth);
    was_empty = (sb.size() == 0);
    if (r && !was_empty) exp_rd = sb.pop_front();
    if (w && !was_full) sb.push_back(d);
    @(posedge wclk);
    #1;
    chk_all(tag);
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
  endtask

  task automatic do_reset(input int edges);
    reset    = 1'b1;
    bus.w_en = 1'b1;
    bus.r_en = 1'b1;
    bus.wr_data = 8'hAA;
    sb.delete();
    exp_rd = '0;
    repeat (edges) @(posedge wclk);
    #1;
    reset    = 1'b0;
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    chk_all("reset");
  endtask

  initial begin
    logic [d_width-1:0] basic[5];
    basic = '{8'd45, 8'd23, 8'd27, 8'd22, 8'd12};
    reset = 1'b0;
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    bus.wr_data = '0;
    exp_rd = '0;
    @(posedge wclk);
    #1;
    do_reset(2);

    // Basic ordering test.
    foreach (basic[i]) cycle(1'b1, 1'b0, basic[i], "basic_wr");
    repeat (3) cycle(1'b0, 1'b1, 8'd0, "basic_rd");
    chk("basic_third", 32'(bus.rd_data), 32'd27);
    cycle(1'b0, 1'b0, 8'd0, "basic_hold");
    chk("basic_left", 32'(sb.size()), 32'd2);
    do_reset(1);

    // Fill the FIFO, overflow it, then drain it and underflow it.
    for (int i = 1; i <= depth; i++) cycle(1'b1, 1'b0, 8'(i), "fill_wr");
    chk("fill_full", 32'(bus.full), 32'd1);
    cycle(1'b1, 1'b0, 8'd99, "overflow");
    for (int i = 1; i <= depth; i++) begin
      cycle(1'b0, 1'b1, 8'd0, "drain_rd");
      chk("drain_val", 32'(bus.rd_data), 32'(i));
    end
    cycle(1'b0, 1'b1, 8'd0, "underflow");
    chk("underflow_hold", 32'(bus.rd_data), 32'd8);

    // Simultaneous read and write with 3 words stored.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(100 + i), "sim_pre");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'(103 + i), "sim_rw");
    chk("sim_occ", 32'(sb.size()), 32'd3);
    repeat (3) cycle(1'b0, 1'b1, 8'd0, "sim_drain");

    // Simultaneous requests at the empty and full boundaries.
    cycle(1'b1, 1'b1, 8'd50, "empty_both");
    chk("empty_both_e", 32'(bus.empty), 32'd0);
    for (int i = 0; i < depth - 1; i++) cycle(1'b1, 1'b0, 8'(60 + i), "bfill");
    chk("bfull", 32'(bus.full), 32'd1);
    cycle(1'b1, 1'b1, 8'd77, "full_both");
    chk("full_both_f", 32'(bus.full), 32'd0);
    chk("full_both_rd", 32'(bus.rd_data), 32'd50);
    repeat (depth - 1) cycle(1'b0, 1'b1, 8'd0, "bdrain");

    // Pointer wrap-around.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 8'(i), "wrap_wr");
      cycle(1'b0, 1'b1, 8'd0, "wrap_rd");
      chk("wrap_val", 32'(bus.rd_data), 32'(i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
